// File: rtl/uwasic_pkg.sv
// Shared constants and register-file layout for the SPI-controlled PWM tile.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uwasic_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CLK_DIV    = 13;
  localparam int NUM_REGS   = 5;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  // Register file contents exported to the PWM/output stage.
  typedef struct packed {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
  } regs_t;

endpackage

// File: rtl/spi_peripheral.sv
// Mode-0 SPI slave: synchronizes pins, frames 16-bit writes, holds the five registers.
// Latency: register updates 1 clk after the synchronized nCS rising edge is seen.
// Backpressure: none; SPI has no flow control, bad frames are silently dropped.
module spi_peripheral
  import uwasic_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  sclk_i,
  input  logic  copi_i,
  input  logic  ncs_i,
  output regs_t regs_o
);

  // [1:0] form the 2-flop synchronizer, [2] holds the previous synchronized value.
  logic [2:0]  sclk_q;
  logic [2:0]  ncs_q;
  logic [1:0]  copi_q;

  // A frame is only framed after a real nCS falling edge, so a reset that lands
  // mid-frame cannot let trailing SCLK edges assemble a bogus frame.
  logic        active_q, active_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  regs_t       regs_q, regs_d;

  logic sclk_rise, ncs_fall, ncs_rise, commit;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];

  assign commit = ncs_rise && active_q && (cnt_q == 5'(FRAME_BITS)) &&
                  shift_q[15] && (shift_q[14:8] <= ADDR_DUTY);

  // Next-state for framing and register file.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    regs_d   = regs_q;
    if (ncs_fall) begin
      active_d = 1'b1;
      cnt_d    = '0;
      shift_d  = '0;
    end else if (ncs_rise) begin
      active_d = 1'b0;
    end else if (active_q && sclk_rise && (cnt_q < 5'(FRAME_BITS))) begin
      shift_d = {shift_q[14:0], copi_q[1]};
      cnt_d   = cnt_q + 5'd1;
    end
    if (commit) begin
      case (shift_q[14:8])
        ADDR_EN_OUT_LO: regs_d.en_out[7:0]  = shift_q[7:0];
        ADDR_EN_OUT_HI: regs_d.en_out[15:8] = shift_q[7:0];
        ADDR_EN_PWM_LO: regs_d.en_pwm[7:0]  = shift_q[7:0];
        ADDR_EN_PWM_HI: regs_d.en_pwm[15:8] = shift_q[7:0];
        ADDR_DUTY:      regs_d.duty         = shift_q[7:0];
        default:        regs_d              = regs_q;
      endcase
    end
  end

  // Synchronizers, framing state and registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q   <= '0;
      ncs_q    <= '0;
      copi_q   <= '0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
      regs_q   <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], sclk_i};
      ncs_q    <= {ncs_q[1:0], ncs_i};
      copi_q   <= {copi_q[0], copi_i};
      active_q <= active_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      regs_q   <= regs_d;
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/tt_um_uwasic_onboarding_oliad.sv
// Tiny Tapeout tile: SPI register file driving 16 output pins with shared-duty PWM.
// Latency: output is registered, 1 clk after enable/PWM state changes.
// Backpressure: none; outputs are free-running.
module tt_um_uwasic_onboarding_oliad
  import uwasic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int           PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

  regs_t          regs;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     pwm_cnt_q, pwm_cnt_d;
  logic [15:0]    out_q, out_d;
  logic           pwm;

  // The tile is always active; these inputs are intentionally left unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

  spi_peripheral u_spi (
    .clk    (clk),
    .rst    (rst),
    .sclk_i (ui_in[0]),
    .copi_i (ui_in[1]),
    .ncs_i  (ui_in[2]),
    .regs_o (regs)
  );

  // PWM timebase and per-channel output selection.
  always_comb begin
    presc_d   = presc_q + PW'(1);
    pwm_cnt_d = pwm_cnt_q;
    if (presc_q == DIV_LAST) begin
      presc_d   = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
    // Full-scale duty must be solid high, which a strict compare cannot give.
    pwm   = (regs.duty == 8'hFF) || (pwm_cnt_q < regs.duty);
    out_d = regs.en_out & (~regs.en_pwm | {16{pwm}});
  end

  // PWM counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_oliad.sv
// Self-checking bench for the SPI-controlled PWM tile.
// Latency: n/a.
// Backpressure: n/a.
module tb_tt_um_uwasic_onboarding_oliad;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic       sclk, copi, ncs;
  logic [7:0] ui_in, uio_in;
  wire  [7:0] uo_out, uio_out, uio_oe;

  assign ui_in = {5'b0, ncs, copi, sclk};

  tt_um_uwasic_onboarding_oliad dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #50 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: register contents indexed by address.
  logic [7:0] m_regs [5];

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    logic [7:0]  exp_uo;
    logic [7:0]  exp_uio;
    string       name;
  } vec_t;

  vec_t vecs [7];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check16m(input string nm, input logic [15:0] act, input logic [15:0] exp,
                          input logic [15:0] mask);
    tests++;
    if ((act & mask) !== (exp & mask)) begin
      fails++;
      $display("FAIL %s: got %h expected %h (mask %h)", nm, act, exp, mask);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
  endtask

  task automatic send_bits(input logic [15:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? fr[15-i] : 1'($urandom);
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  // Full transaction: select, shift, deselect, allow commit and output latency.
  task automatic spi_frame(input logic [15:0] fr, input int nbits);
    ncs = 1'b0;
    tick(4);
    send_bits(fr, nbits);
    tick(4);
    ncs = 1'b1;
    tick(8);
    if (nbits >= 16 && fr[15] && fr[14:8] <= 7'd4) m_regs[fr[10:8]] = fr[7:0];
  endtask

  function automatic logic [15:0] model_out();
    logic [15:0] en_o, en_p, pw;
    en_o = {m_regs[1], m_regs[0]};
    en_p = {m_regs[3], m_regs[2]};
    pw   = (m_regs[4] == 8'hFF) ? 16'hFFFF : 16'h0000;
    return en_o & (~en_p | pw);
  endfunction

  // PWM channels are only phase-independent at duty 0 or full scale.
  function automatic logic [15:0] model_mask();
    if (m_regs[4] == 8'h00 || m_regs[4] == 8'hFF) return 16'hFFFF;
    return ~{m_regs[3], m_regs[2]};
  endfunction

  task automatic wait_bit0(input logic v, output int n);
    n = 0;
    while (uo_out[0] !== v && n < 8000) begin
      tick(1);
      n++;
    end
    if (uo_out[0] !== v) n = -100000;
  endtask

  initial begin
    int          hi, lo, w, cnt;
    logic [15:0] fr;
    int          nb;
    int          lens [7] = '{12, 15, 16, 16, 16, 17, 20};

    vecs[0] = '{16'h80F0, 16, 8'hF0, 8'h00, "wr_en_lo"};
    vecs[1] = '{16'h81CC, 16, 8'hF0, 8'hCC, "wr_en_hi"};
    vecs[2] = '{16'h00FF, 16, 8'hF0, 8'hCC, "read_ignored"};
    vecs[3] = '{16'hB0AA, 16, 8'hF0, 8'hCC, "addr30_ignored"};
    vecs[4] = '{16'h80AB, 12, 8'hF0, 8'hCC, "short_ignored"};
    vecs[5] = '{16'h8555, 16, 8'hF0, 8'hCC, "addr05_ignored"};
    vecs[6] = '{16'h8003, 20, 8'h03, 8'hCC, "long_saturates"};

    rst = 1'b1; ena = 1'b1; uio_in = 8'h00;
    sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    model_reset();
    tick(3);
    check8("rst_held_uo", uo_out, 8'h00);
    check8("rst_held_uio", uio_out, 8'h00);
    check8("uio_oe", uio_oe, 8'hFF);
    rst = 1'b0;
    tick(6);
    check8("post_rst_uo", uo_out, 8'h00);
    check8("post_rst_uio", uio_out, 8'h00);

    for (int i = 0; i < 7; i++) begin
      spi_frame(vecs[i].frame, vecs[i].nbits);
      check8({vecs[i].name, "_uo"}, uo_out, vecs[i].exp_uo);
      check8({vecs[i].name, "_uio"}, uio_out, vecs[i].exp_uio);
    end

    // PWM on channel 0 at 50%.
    spi_frame(16'h8001, 16);
    spi_frame(16'h8100, 16);
    spi_frame(16'h8201, 16);
    spi_frame(16'h8300, 16);
    spi_frame(16'h8480, 16);
    wait_bit0(1'b0, w);
    wait_bit0(1'b1, w);
    check_range("pwm_sync", w, 0, 8000);
    wait_bit0(1'b0, hi);
    wait_bit0(1'b1, lo);
    check_range("pwm50_high", hi, 1664 - 13, 1664 + 13);
    check_range("pwm50_period", hi + lo, 3327, 3329);

    spi_frame(16'h8400, 16);
    cnt = 0;
    for (int i = 0; i < 6656; i++) begin
      if (uo_out[0] !== 1'b0) cnt++;
      tick(1);
    end
    check_range("duty00_high_samples", cnt, 0, 0);

    spi_frame(16'h84FF, 16);
    cnt = 0;
    for (int i = 0; i < 6656; i++) begin
      if (uo_out[0] !== 1'b1) cnt++;
      tick(1);
    end
    check_range("dutyFF_low_samples", cnt, 0, 0);

    // Reset while running, then a normal write must still be accepted.
    rst = 1'b1;
    tick(2);
    check8("midrun_rst_uo", uo_out, 8'h00);
    rst = 1'b0;
    model_reset();
    tick(2);
    check8("after_rst_uo", uo_out, 8'h00);
    check8("after_rst_uio", uio_out, 8'h00);
    spi_frame(16'h80F0, 16);
    check8("after_rst_write_uo", uo_out, 8'hF0);

    // Reset mid-frame: nCS stays low, so the following 16 bits must not commit.
    ncs = 1'b0;
    tick(4);
    send_bits(16'h8100, 8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    send_bits(16'h80FF, 16);
    tick(4);
    ncs = 1'b1;
    tick(8);
    check8("midframe_rst_uo", uo_out, 8'h00);
    check8("midframe_rst_uio", uio_out, 8'h00);

    // Randomized traffic against the register-level model.
    for (int k = 0; k < 40; k++) begin
      fr[15]   = ($urandom_range(0, 9) < 8);
      fr[14:8] = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 4)) : 7'($urandom);
      fr[7:0]  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) fr[14:8] = 7'h04;
      if ($urandom_range(0, 7) == 0) fr[7:0] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      nb = lens[$urandom_range(0, 6)];
      spi_frame(fr, nb);
      check16m("rand_out", {uio_out, uo_out}, model_out(), model_mask());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_um_uwasic_onboarding_oliad.md
Name: tt_um_uwasic_onboarding_oliad

Overview:
- Tiny Tapeout user tile: SPI-slave register file driving 16 output pins, each with optional PWM.
- Five 8-bit registers, written over mode-0 SPI, select per-pin enable, per-pin PWM enable and one shared PWM duty cycle.
- Pins: uo_out = outputs 7:0; uio_out = outputs 15:8; uio path is output-only.

Parameters:
- CLK_DIV, 13, system clocks per PWM counter step; at 10 MHz the PWM period is 13*256 = 3328 clocks, about 3.005 kHz.
- NUM_REGS, 5, number of implemented register addresses (0x00..0x04).

Ports:
- clk  in  1  system clock, 10 MHz nominal
- rst  in  1  synchronous active-high reset
- ena  in  1  tile enable; ignored, design always active
- ui_in  in  8  [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused
- uio_in  in  8  unused
- uo_out  out  8  output channels 7:0
- uio_out  out  8  output channels 15:8
- uio_oe  out  8  constant 8'hFF

Behaviour:
- Reset (rst=1 at a clk edge): all five registers, synchronizers, SPI shift state and PWM counters go to 0. uo_out and uio_out read 0 while reset is held and until a register write occurs.
- Synchronization: SCLK, COPI and nCS pass through 2-flop synchronizers. SCLK rising edge and nCS rising/falling edges are detected on the synchronized copies. Requirement: SCLK at most clk/8.
- SPI framing:
  - nCS falling edge clears the bit counter and shift register.
  - Each SCLK rising edge while nCS is low shifts in COPI, MSB first.
  - Frame is 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
  - Bits beyond 16 are ignored; the counter saturates at 16.
- Commit: on the nCS rising edge, the frame is applied only if the count is exactly 16, R/W=1 and address <= 0x04. The register updates 1 clk after the edge is detected.
  - Short frames, reads (R/W=0) and addresses 0x05..0x7F are discarded with no side effects.
  - No read-back path exists; COPI data is never echoed.
- Register map:
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty[7:0]
- PWM:
  - Prescaler counts 0..CLK_DIV-1; on wrap, an 8-bit counter increments (wraps 255 -> 0).
  - pwm = 1 if duty == 8'hFF, else (counter < duty).
  - duty=0 gives constant 0. Duty changes take effect immediately, without waiting for period end.
- Output per channel i: out[i] = en_out[i] & (en_pwm[i] ? pwm : 1). The output is registered, adding 1 clk latency. en_pwm without en_out gives 0.
- Reset mid-frame: the frame is abandoned. The next frame must start with a fresh nCS falling edge.

Decomposition:
- Package uwasic_pkg:
  - Address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_DUTY=0x04.
  - FRAME_BITS=16, CLK_DIV=13.
- Sub-module spi_peripheral: synchronizers, framing and register file; exports the five registers.
- Top level: PWM generator, output mux and pin mapping.

Test Plan:
- Reset, then write 0x00<-0xF0 (frame 0x80F0) -> uo_out=0xF0, uio_out=0x00.
- Write 0x01<-0xCC -> uio_out=0xCC. Then a read frame 0x00FF -> no register change.
- Address 0x30, data 0xAA (frame 0xB0AA), and a 12-bit truncated frame -> all outputs unchanged.
- en_out[0]=1, en_pwm[0]=1, duty=0x80 -> uo_out[0] period 3328±1 clk, high 1664±13 clk (50%).
- Same setup, duty=0x00 -> uo_out[0] constant 0. duty=0xFF -> constant 1 over 2 periods.
- Mid-run assert rst for 2 clk -> all outputs 0; a subsequent write frame is accepted normally.
